mem_byte_sequencer: RTL and testbench
=====================================

// Module: mem_byte_sequencer
// PURPOSE
//  MEM-stage access sequencer between the EX/MEM register and a byte-wide (256x8) data RAM.
//  Breaks word/halfword/byte loads and stores into one-byte-per-cycle RAM accesses, big-endian.
//  Raises stall to the hazard unit while busy; its rdata feeds the MEM result mux and MEM/WB.
// PARAMETERS
//  ADDR_W       8  byte-address width of the data RAM (depth = 2**ADDR_W)
//  ALIGN_CHECK  1  1 = misaligned halfword/word flags err; 0 = access performed unaligned
// PORTS
//  CLK        in   1      clock; all state changes on rising edge
//  CLR        in   1      synchronous, active-high reset
//  req_en     in   1      memory access requested (EX/MEM Mem_Enable)
//  req_rw     in   1      1 = store, 0 = load
//  req_size   in   2      00 byte, 01 halfword, 10 word, 11 reserved
//  req_addr   in   32     byte address (EX/MEM ALU result)
//  req_wdata  in   32     store data (EX/MEM port C)
//  ram_addr   out  ADDR_W byte address to RAM
//  ram_wdata  out  8      byte to RAM
//  ram_we     out  1      RAM write strobe, one byte per cycle
//  ram_rdata  in   8      RAM read byte, combinational from ram_addr
//  rdata      out  32     load result, zero-extended, valid while done=1
//  done       out  1      one-cycle pulse: access complete
//  err        out  1      with done: size 11, out of range, or misaligned (ALIGN_CHECK=1)
//  stall      out  1      freeze PC, IF/ID, ID/EX, EX/MEM this cycle
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0; rdata=0, done=0, err=0, stall=0, ram_we=0, ram_addr=0, ram_wdata=0.
//  N = bytes: 1/2/4 for size 00/01/10. Request fields latched at acceptance; later changes ignored.
//  IDLE: stall = req_en (combinational). On edge with req_en=1: latch request, clear rdata;
//    legal -> ACCESS, cnt=0; illegal -> DONE with err=1, no RAM write ever issued.
//  Illegal: size 11; req_addr[31:ADDR_W]!=0; addr+N-1 > 2**ADDR_W-1 (no wrap);
//    ALIGN_CHECK=1 and (size 01 & addr[0]) or (size 10 & addr[1:0]!=0).
//  ACCESS: stall=1; ram_addr = addr+cnt (ADDR_W bits).
//    store: ram_we=1, ram_wdata = wdata[8*(N-1-cnt) +: 8] (MSB first).
//    load: ram_we=0; on edge rdata <= {rdata[23:0], ram_rdata}.
//    cnt increments each edge; on cnt==N-1 -> DONE.
//  DONE: done=1, stall=0, err as decided; rdata holds. Next edge -> IDLE unconditionally
//    (pipeline advances on this edge, so the same request is never re-accepted).
//  Stage occupancy: N+2 cycles (accept, N access, done); back-to-back requests add no bubble
//    beyond DONE->IDLE.
//  Stores: rdata stays 0. Byte/halfword loads are zero-extended in rdata[31:8*N].
//  req_en=0 in IDLE: outputs idle; ram_we never asserted outside ACCESS.
//  CLR in any state, including mid-ACCESS: IDLE next edge, reset values; bytes already written
//    stay (no rollback), no done pulse.
// TESTING
//  1 RAM[0x10..0x13]=AA BB CC DD; word load addr 0x10 -> stall 5 cycles, done cycle 6, rdata=AABBCCDD.
//  2 Halfword store 0x1234ABCD @0x20 -> ram_we 2 cycles; RAM[0x20]=AB, [0x21]=CD; [0x22] untouched.
//  3 Byte load @0xFF with RAM[0xFF]=80 -> rdata=00000080; word load @0xFC ok; @0xFE -> err=1, no RAM traffic.
//  4 Word load @0x11 (ALIGN_CHECK=1) -> done+err after 2 cycles, rdata=0; size 11 -> same.
//  5 CLR asserted in 2nd ACCESS cycle of word store -> only first byte written; IDLE, stall=0, no done.
//  6 Back-to-back byte store then word load with req_en held -> each accepted once; 3+6 cycles total.

Source files
------------

// File: rtl/mem_byte_sequencer.sv
// -----------------------------------------------------------------------------
// mem_byte_sequencer
//
// MEM-stage access sequencer that sits between the EX/MEM pipeline register and
// a byte-wide data RAM. Word, halfword and byte loads/stores are broken into one
// RAM access per cycle, most-significant byte first (big-endian). While an access
// is in flight the block raises stall so the hazard unit can freeze the front of
// the pipeline; the assembled load result feeds the MEM result mux and MEM/WB.
//
// Occupancy of a legal request is N+2 cycles (accept, N byte accesses, done),
// where N = 1/2/4 for byte/halfword/word. Illegal requests take 2 cycles
// (accept, done with err) and never touch the RAM.
//
// Parameters
//   ADDR_W       byte-address width of the data RAM (depth = 2**ADDR_W), < 32
//   ALIGN_CHECK  1: misaligned halfword/word is an error; 0: performed unaligned
//
// Ports
//   CLK        in   clock, all state changes on the rising edge
//   CLR        in   synchronous active-high reset
//   req_en     in   memory access requested (EX/MEM Mem_Enable)
//   req_rw     in   1 = store, 0 = load
//   req_size   in   00 byte, 01 halfword, 10 word, 11 reserved
//   req_addr   in   byte address (EX/MEM ALU result)
//   req_wdata  in   store data (EX/MEM port C)
//   ram_addr   out  byte address to RAM (0 when not accessing)
//   ram_wdata  out  byte to RAM (0 when not storing)
//   ram_we     out  RAM write strobe, one byte per cycle
//   ram_rdata  in   RAM read byte, combinational from ram_addr
//   rdata      out  load result, zero-extended, valid while done=1
//   done       out  one-cycle completion pulse
//   err        out  qualifies done: reserved size, out of range or misaligned
//   stall      out  freeze PC, IF/ID, ID/EX, EX/MEM this cycle
// -----------------------------------------------------------------------------
module mem_byte_sequencer #(
  parameter int ADDR_W      = 8,
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              req_en,
  input  logic              req_rw,
  input  logic [1:0]        req_size,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              ram_we,
  input  logic [7:0]        ram_rdata,
  output logic [31:0]       rdata,
  output logic              done,
  output logic              err,
  output logic              stall
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  // Request size encodings.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Largest byte address of the RAM, widened so the end-address compare
  // cannot wrap.
  localparam logic [32:0] MAX_ADDR = (33'd1 << ADDR_W) - 33'd1;

  state_t            state;
  logic [1:0]        cnt;      // byte index within the current access
  logic [1:0]        last_q;   // N-1 of the latched request
  logic [ADDR_W-1:0] base_q;   // latched start address
  logic [31:0]       wdata_q;  // latched store data
  logic              rw_q;     // latched direction
  logic              err_q;    // verdict of the legality check

  // ---------------------------------------------------------------------------
  // Request decode and legality check (only consumed in IDLE)
  // ---------------------------------------------------------------------------
  logic [1:0]  req_last;     // N-1 for the incoming request
  logic [32:0] req_end;      // address of the last byte touched
  logic        range_ok;
  logic        misaligned;
  logic        req_legal;

  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path through the case can leave it unassigned and infer a
    // latch.
    req_last = 2'd0;
    case (req_size)
      SZ_HALF: req_last = 2'd1;
      SZ_WORD: req_last = 2'd3;
      default: req_last = 2'd0;
    endcase

    req_end    = {1'b0, req_addr} + {31'd0, req_last};
    range_ok   = ((req_addr >> ADDR_W) == 32'd0) && (req_end <= MAX_ADDR);
    misaligned = ALIGN_CHECK &&
                 (((req_size == SZ_HALF) && req_addr[0]) ||
                  ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00)));
    req_legal  = (req_size != 2'b11) && range_ok && !misaligned;
  end

  // ---------------------------------------------------------------------------
  // Sequencer state
  // ---------------------------------------------------------------------------
  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others, whatever the order of
  // statements.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state   <= S_IDLE;
      cnt     <= 2'd0;
      last_q  <= 2'd0;
      base_q  <= '0;
      wdata_q <= 32'd0;
      rw_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata   <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_en) begin
            base_q  <= req_addr[ADDR_W-1:0];
            wdata_q <= req_wdata;
            rw_q    <= req_rw;
            last_q  <= req_last;
            cnt     <= 2'd0;
            rdata   <= 32'd0;
            err_q   <= !req_legal;
            state   <= req_legal ? S_ACCESS : S_DONE;
          end
        end

        S_ACCESS: begin
          // Loads shift bytes in from the right; clearing rdata at acceptance
          // leaves short loads zero-extended.
          if (!rw_q) begin
            rdata <= {rdata[23:0], ram_rdata};
          end
          cnt <= cnt + 2'd1;
          if (cnt == last_q) begin
            state <= S_DONE;
          end
        end

        S_DONE: begin
          // The pipeline advances on this edge, so the request that just
          // finished is gone before IDLE looks at req_en again.
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs, decoded from the registered state
  // ---------------------------------------------------------------------------
  logic       in_access;
  logic [1:0] byte_sel;    // which store-data byte goes out this cycle

  assign in_access = (state == S_ACCESS);
  assign byte_sel  = last_q - cnt;   // MSB first: N-1 down to 0

  assign done  = (state == S_DONE);
  assign err   = done && err_q;
  // In IDLE the stall has to cover the acceptance cycle itself, so it follows
  // req_en directly rather than waiting for the state to change.
  assign stall = in_access || ((state == S_IDLE) && req_en);

  // CLR masks the strobe so a reset raised mid-store stops the byte of that
  // cycle from reaching the RAM; bytes written earlier are left in place.
  assign ram_we    = in_access && rw_q && !CLR;
  assign ram_addr  = in_access ? (base_q + ADDR_W'(cnt)) : '0;
  assign ram_wdata = (in_access && rw_q) ? wdata_q[{byte_sel, 3'b000} +: 8] : 8'd0;

endmodule

// File: tb/tb_mem_byte_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mem_byte_sequencer
//
// Self-checking bench for mem_byte_sequencer (ADDR_W=8, ALIGN_CHECK=1). A 256x8
// RAM with combinational read is attached to the RAM port. The reference model
// works at transaction level: a shadow byte array plus the legality rules and
// cycle counts (N+2 or 2) computed with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_mem_byte_sequencer;

  logic        CLK = 1'b0;
  logic        CLR;
  logic        req_en;
  logic        req_rw;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [7:0]  ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic [7:0]  ram_rdata;
  logic [31:0] rdata;
  logic        done;
  logic        err;
  logic        stall;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mem     [256];   // RAM attached to the DUT
  logic [7:0] ref_mem [256];   // expected RAM contents

  always #5 CLK = ~CLK;

  mem_byte_sequencer #(.ADDR_W(8), .ALIGN_CHECK(1'b1)) dut (
    .CLK       (CLK),
    .CLR       (CLR),
    .req_en    (req_en),
    .req_rw    (req_rw),
    .req_size  (req_size),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_rdata (ram_rdata),
    .rdata     (rdata),
    .done      (done),
    .err       (err),
    .stall     (stall)
  );

  always @(posedge CLK) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
  end
  assign ram_rdata = mem[ram_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs one request from IDLE (called #1 after a rising edge) and checks it
  // against the transaction-level model. Returns the rdata seen with done.
  task automatic run_req(input logic rw, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input string tag, output logic [31:0] got);
    int          n;
    longint      a;
    bit          legal;
    logic [31:0] exp_rdata;
    int          done_cyc;
    int          stalls;
    int          wes;

    n     = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    a     = longint'(addr);
    legal = (size != 2'd3) && (a + n - 1 <= 255) &&
            !((size == 2'd1) && addr[0]) &&
            !((size == 2'd2) && (addr[1:0] != 2'b00));

    exp_rdata = 32'd0;
    if (legal) begin
      for (int i = 0; i < n; i++) begin
        if (rw) ref_mem[8'(a + i)] = 8'(wdata >> (8 * (n - 1 - i)));
        else    exp_rdata = {exp_rdata[23:0], ref_mem[8'(a + i)]};
      end
    end

    req_en = 1'b1; req_rw = rw; req_size = size; req_addr = addr; req_wdata = wdata;
    done_cyc = 0; stalls = 0; wes = 0; got = 32'hDEADBEEF;
    for (int c = 1; c <= 12 && done_cyc == 0; c++) begin
      @(negedge CLK);
      if (stall)  stalls++;
      if (ram_we) wes++;
      if (done) begin
        done_cyc = c;
        got      = rdata;
        check({tag, "_rdata"}, rdata, exp_rdata);
        check({tag, "_err"}, 32'(err), 32'(!legal));
      end
      @(posedge CLK); #1;
      if (c == 1) begin
        // Fields change after acceptance; the DUT must ignore them.
        req_en = 1'b0; req_rw = 1'($urandom); req_size = 2'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
      end
    end
    check({tag, "_done_cycle"}, 32'(done_cyc), legal ? 32'(n + 2) : 32'd2);
    check({tag, "_stall_cycles"}, 32'(stalls), legal ? 32'(n + 1) : 32'd1);
    check({tag, "_we_cycles"}, 32'(wes), (legal && rw) ? 32'(n) : 32'd0);

    @(negedge CLK);
    check({tag, "_idle_after"}, {29'd0, done, stall, ram_we}, 32'd0);
    @(posedge CLK); #1;
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] exp_w;
    int          dones;
    int          first_done;
    int          second_done;
    int          mism;

    CLR = 1'b1; req_en = 1'b0; req_rw = 1'b0; req_size = 2'd0;
    req_addr = 32'd0; req_wdata = 32'd0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("reset_outputs", {rdata[15:0], ram_addr, 3'd0, done, err, stall, ram_we}, 32'd0);
    check("reset_rdata_hi", {rdata[31:16], ram_wdata, 8'd0}, 32'd0);
    @(posedge CLK); #1;
    CLR = 1'b0;

    // Fill the whole RAM with random words through the DUT itself.
    for (int i = 0; i < 64; i++) run_req(1'b1, 2'd2, 32'(4 * i), $urandom, "init", got);

    // Word load returns bytes in big-endian order.
    run_req(1'b1, 2'd2, 32'h10, 32'hAABBCCDD, "t1_store", got);
    run_req(1'b0, 2'd2, 32'h10, 32'h0, "t1_load", got);
    check("t1_const", got, 32'hAABBCCDD);

    // Halfword store touches exactly two bytes.
    run_req(1'b1, 2'd1, 32'h20, 32'h1234ABCD, "t2_store", got);
    check("t2_mem20", 32'(mem[8'h20]), 32'h000000AB);
    check("t2_mem21", 32'(mem[8'h21]), 32'h000000CD);
    check("t2_mem22", 32'(mem[8'h22]), 32'(ref_mem[8'h22]));

    // Top of the address space.
    run_req(1'b1, 2'd0, 32'hFF, 32'h00000080, "t3_store", got);
    run_req(1'b0, 2'd0, 32'hFF, 32'h0, "t3_load_ff", got);
    check("t3_const", got, 32'h00000080);
    run_req(1'b0, 2'd2, 32'hFC, 32'h0, "t3_word_fc", got);
    run_req(1'b0, 2'd2, 32'hFE, 32'h0, "t3_word_fe", got);
    run_req(1'b0, 2'd1, 32'hFE, 32'h0, "t3_half_fe", got);
    run_req(1'b1, 2'd0, 32'h100, 32'h55, "t3_hi_bits", got);

    // Misaligned and reserved size.
    run_req(1'b0, 2'd2, 32'h11, 32'h0, "t4_mis_word", got);
    check("t4_mis_rdata", got, 32'h0);
    run_req(1'b0, 2'd3, 32'h10, 32'h0, "t4_size3", got);
    run_req(1'b1, 2'd1, 32'h21, 32'hFFFF, "t4_mis_half", got);

    // CLR during the second byte of a word store.
    req_en = 1'b1; req_rw = 1'b1; req_size = 2'd2; req_addr = 32'h40; req_wdata = 32'h11223344;
    @(posedge CLK); #1;
    req_en = 1'b0;
    @(posedge CLK); #1;
    CLR = 1'b1;
    @(posedge CLK); #1;
    CLR = 1'b0;
    ref_mem[8'h40] = 8'h11;
    @(negedge CLK);
    check("t5_after_clr", {27'd0, done, err, stall, ram_we, 1'b0}, 32'd0);
    check("t5_rdata", rdata, 32'd0);
    dones = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      if (done) dones++;
    end
    check("t5_no_done", 32'(dones), 32'd0);
    check("t5_mem40", 32'(mem[8'h40]), 32'h00000011);
    check("t5_mem41", 32'(mem[8'h41]), 32'(ref_mem[8'h41]));
    @(posedge CLK); #1;

    // Back-to-back byte store then word load with req_en held high.
    ref_mem[8'h50] = 8'h5A;
    exp_w = {8'h5A, ref_mem[8'h51], ref_mem[8'h52], ref_mem[8'h53]};
    req_en = 1'b1; req_rw = 1'b1; req_size = 2'd0; req_addr = 32'h50; req_wdata = 32'h0000005A;
    dones = 0; first_done = 0; second_done = 0; got = 32'd0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge CLK);
      if (c == 3) check("t6_stall_done", 32'(stall), 32'd0);
      if (c == 4) check("t6_stall_accept2", 32'(stall), 32'd1);
      if (done) begin
        dones++;
        if (dones == 1) first_done = c;
        if (dones == 2) begin second_done = c; got = rdata; end
        check("t6_err", 32'(err), 32'd0);
      end
      @(posedge CLK); #1;
      if (c == 1) begin req_rw = 1'b0; req_size = 2'd2; end
      if (c == 4) req_en = 1'b0;
    end
    check("t6_dones", 32'(dones), 32'd2);
    check("t6_first_done", 32'(first_done), 32'd3);
    check("t6_second_done", 32'(second_done), 32'd9);
    check("t6_rdata", got, exp_w);

    // Random mix of loads and stores, legal and illegal.
    for (int k = 0; k < 60; k++) begin
      logic [31:0] ra;
      ra = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 255));
      run_req(1'($urandom), 2'($urandom_range(0, 3)), ra, $urandom, "rand", got);
    end

    // Whole RAM image against the shadow copy.
    mism = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) mism++;
    check("ram_image_mismatches", 32'(mism), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
